// File: rtl/pipe_stage_reg_gen.sv
// Parametrised inter-stage pipeline register with valid/flush, multicycle aux loop-back
// and optional stall/bubble performance counters (enabled by `define STAGE_REG_PERF_EN).
module pipe_stage_reg_gen #(
  parameter int                       PAYLOAD_W   = 144,
  parameter int                       AUX_W       = 66,
  parameter int                       STALL_W     = 6,
  parameter int                       STAGE_IDX   = 3,
  parameter logic [PAYLOAD_W-1:0]     NOP_PAYLOAD = '0,
  parameter int                       CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_W-1:0]   stall,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [AUX_W-1:0]     aux_i,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [AUX_W-1:0]     aux_o,
  output logic [CNT_W-1:0]     stall_run,
  output logic [CNT_W-1:0]     bubble_total
);

  typedef enum logic [2:0] {
    M_RESET,
    M_FLUSH,
    M_BUBBLE,
    M_ADVANCE,
    M_HOLD
  } mode_t;

  logic  up;
  logic  dn;
  mode_t mode;

  // Only this stage's pair of stall bits matters; the rest are deliberately ignored.
  logic unused_stall;
  assign unused_stall = ^stall;

  assign up = stall[STAGE_IDX];
  assign dn = stall[STAGE_IDX+1];

  always_comb begin
    mode = M_HOLD;
    if (rst)             mode = M_RESET;
    else if (flush)      mode = M_FLUSH;
    else if (up && !dn)  mode = M_BUBBLE;
    else if (!up)        mode = M_ADVANCE;
    else                 mode = M_HOLD;
  end

  logic                 valid_reg;
  logic [PAYLOAD_W-1:0] payload_reg;
  logic [AUX_W-1:0]     aux_reg;

  always_ff @(posedge clk) begin
    case (mode)
      M_RESET, M_FLUSH: begin
        valid_reg   <= 1'b0;
        payload_reg <= NOP_PAYLOAD;
        aux_reg     <= '0;
      end
      M_BUBBLE: begin
        valid_reg   <= 1'b0;
        payload_reg <= NOP_PAYLOAD;
        aux_reg     <= aux_i;
      end
      M_ADVANCE: begin
        valid_reg   <= in_valid;
        payload_reg <= in_valid ? in_payload : NOP_PAYLOAD;
        aux_reg     <= '0;
      end
      default: begin
        // HOLD keeps the instruction in place while the stalled stage iterates.
        aux_reg     <= aux_i;
      end
    endcase
  end

  assign out_valid   = valid_reg;
  assign out_payload = payload_reg;
  assign aux_o       = aux_reg;

`ifdef STAGE_REG_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] run_reg;
  logic [CNT_W-1:0] bub_reg;
  logic [CNT_W-1:0] run_inc;
  logic [CNT_W-1:0] bub_inc;

  assign run_inc = (run_reg == CNT_MAX) ? run_reg : run_reg + CNT_W'(1);
  assign bub_inc = (bub_reg == CNT_MAX) ? bub_reg : bub_reg + CNT_W'(1);

  always_ff @(posedge clk) begin
    case (mode)
      M_RESET: begin
        run_reg <= '0;
        bub_reg <= '0;
      end
      M_BUBBLE: begin
        run_reg <= run_inc;
        bub_reg <= bub_inc;
      end
      M_HOLD:  run_reg <= run_inc;
      default: run_reg <= '0;
    endcase
  end

  assign stall_run    = run_reg;
  assign bubble_total = bub_reg;
`else
  assign stall_run    = '0;
  assign bubble_total = '0;
`endif

endmodule
